// File: rtl/mul_seq_if.sv
// mul_seq_if: request/result bundle between a multiply requester and mul_seq
interface mul_seq_if #(
    parameter int W = 4
);
    logic           start;
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;
    modport master(output start, sgn, a, b, input busy, done, p);
    modport slave(input start, sgn, a, b, output busy, done, p);
endinterface

// File: rtl/mul_seq.sv
// mul_seq: radix-2 sequential shift-add multiplier, unsigned or two's-complement signed
module mul_seq #(
    parameter int W = 4
) (
    input logic      ck,
    input logic      rst_n,
    mul_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW = $clog2(W + 1);
    state_t         state;
    logic [2*W-1:0] acc, mc, p_r, sum;
    logic [W:0]     mp, mag_a, mag_b;
    logic [CW-1:0]  cnt;
    logic           neg, busy_r, done_r;
    // W+1-bit magnitudes so the most negative operand needs no special case
    always_comb begin
        mag_a = (bus.sgn && bus.a[W-1]) ? (W+1)'(0) - {1'b1, bus.a} : {1'b0, bus.a};
        mag_b = (bus.sgn && bus.b[W-1]) ? (W+1)'(0) - {1'b1, bus.b} : {1'b0, bus.b};
        sum   = acc + (mp[0] ? mc : '0);
    end
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mc     <= '0;
            mp     <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            p_r    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    acc    <= '0;
                    mc     <= (2*W)'(mag_a);
                    mp     <= mag_b;
                    cnt    <= CW'(W);
                    neg    <= bus.sgn & (bus.a[W-1] ^ bus.b[W-1]);
                    busy_r <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    acc <= sum;
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    cnt <= cnt - CW'(1);
                    // last step: publish the completed sum directly
                    if (cnt == CW'(1)) begin
                        p_r    <= neg ? -sum : sum;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.p    = p_r;
endmodule
